// File: rtl/seq_rca_adder.sv
// Digit-serial ripple-carry add/sub unit: DIGIT bits per cycle, start/done handshake.
// Optional macro SEQ_RCA_SAT_EN saturates Res to the signed limit on overflow.
module seq_rca_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Res,
  output logic             C,
  output logic             V
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic [DIGIT-1:0]   w_a_dig;
  logic [DIGIT-1:0]   w_b_dig;
  logic [DIGIT:0]     w_sum;
  logic               w_c_msb_in;
  logic [WIDTH-1:0]   w_res_next;
  logic [WIDTH-1:0]   w_res_final;

  // One ripple slice; the carry into the slice MSB is recovered from the MSB sum bit.
  assign w_a_dig    = r_a[DIGIT-1:0];
  assign w_b_dig    = r_b[DIGIT-1:0];
  assign w_sum      = {1'b0, w_a_dig} + {1'b0, w_b_dig} + (DIGIT+1)'(r_carry);
  assign w_c_msb_in = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1];

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_res_next = w_sum[DIGIT-1:0];
    end else begin : g_multi
      assign w_res_next = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SEQ_RCA_SAT_EN
  logic r_a_sign;
  assign w_res_final = !r_ovf ? r_res :
                       r_a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_res_final = r_res;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Res     <= '0;
      C       <= 1'b0;
      V       <= 1'b0;
`ifdef SEQ_RCA_SAT_EN
      r_a_sign <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub | Cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
`ifdef SEQ_RCA_SAT_EN
            r_a_sign <= A[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_sum[DIGIT];
          r_ovf   <= w_c_msb_in ^ w_sum[DIGIT];
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          if (r_cnt == CNT_W'(N - 1)) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          Res     <= w_res_final;
          C       <= r_carry;
          V       <= r_ovf;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_rca_adder.sv
// Self-checking bench for seq_rca_adder (WIDTH=16, DIGIT=4): vector table,
// handshake corner sequences and randomized operations against an arithmetic model.
module tb_seq_rca_adder;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         busy;
  logic         done;
  logic [W-1:0] Res;
  logic         C;
  logic         V;

  int n_tests = 0;
  int n_fail  = 0;

  seq_rca_adder #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .busy(busy), .done(done), .Res(Res), .C(C), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: full-width sum, sign rule for overflow.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, output logic [W-1:0] res, output logic c,
                           output logic v);
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
    res = s[W-1:0];
    c   = s[W];
    v   = (a[W-1] == bb[W-1]) && (res[W-1] != a[W-1]);
`ifdef SEQ_RCA_SAT_EN
    if (v) res = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
  endtask

  // Full handshake: checks latency, busy length, single done pulse, results and hold.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W-1:0] er,
                       input logic ec, input logic ev);
    int lat;
    int busy_cnt;
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    busy_cnt = 1;
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, 32'(lat), 32'(N + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(N));
    check({tag, " Res"}, 32'(Res), 32'(er));
    check({tag, " C"}, 32'(C), 32'(ec));
    check({tag, " V"}, 32'(V), 32'(ev));
    @(posedge clk);
    #1;
    check({tag, " done_pulse_width"}, 32'(done), 32'd0);
    check({tag, " Res_hold"}, 32'(Res), 32'(er));
  endtask

  vec_t         vecs[8];
  logic [W-1:0] mr;
  logic         mc;
  logic         mv;
  int           dones;
  logic [W-1:0] res_at_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
`ifdef SEQ_RCA_SAT_EN
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
    vecs[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[7] = '{16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0};

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset Res", 32'(Res), 32'd0);
    check("reset C", 32'(C), 32'd0);
    check("reset V", 32'(V), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].res, vecs[i].c, vecs[i].v);

    // start re-pulsed with other operands mid-run must be ignored.
    @(negedge clk);
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(posedge clk);
    dones = 0;
    res_at_done = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = (i == 2 || i == 3);
      A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        res_at_done = Res;
      end
    end
    check("repulse done_count", 32'(dones), 32'd1);
    check("repulse Res", 32'(res_at_done), 32'h5555);
    check("repulse C", 32'(C), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (t % 8 == 0) ra = 16'h7FFF;
      if (t % 8 == 1) ra = 16'h8000;
      ref_model(ra, rb, rc, rs, mr, mc, mv);
      do_op($sformatf("rand%0d", t), ra, rb, rc, rs, mr, mc, mv);
    end

    // Asynchronous reset on cycle 2 of a run aborts the operation.
    do_op("pre_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    A = 16'h7FFF; B = 16'h0001; Cin = 1'b1; Sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort Res", 32'(Res), 32'd0);
    check("abort C", 32'(C), 32'd0);
    check("abort V", 32'(V), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    do_op("post_reset", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
